// File: rtl/instr_seq_pkg.sv
// -----------------------------------------------------------------------------
// instr_seq_pkg
//   Shared encodings for the instruction sequencer:
//     - state_e   : sequencer FSM states
//     - pc_sel_e  : PC source select codes driven to the PC address mux
//     - mem_sel_e : memory address source select codes
// -----------------------------------------------------------------------------
package instr_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_DMEM  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PC_ALU = 2'd0,  // branch/jump target from the ALU
    PC_P4  = 2'd1,  // PC + 4, advance past the fetched instruction
    PC_M4  = 2'd2,  // PC - 4, step back to replay the current instruction
    PC_OLD = 2'd3   // hold
  } pc_sel_e;

  typedef enum logic {
    MEM_PC  = 1'b0,  // instruction fetch address
    MEM_ALU = 1'b1   // data access address
  } mem_sel_e;

endpackage

// File: rtl/instr_seq.sv
// -----------------------------------------------------------------------------
// instr_seq
//   Multi-cycle instruction sequencer: fetch, one-cycle execute, optional data
//   memory access, halt and fault handling. Data-access errors replay the
//   instruction (PC stepped back by 4) up to MAX_RETRY times; any memory
//   request waiting TIMEOUT cycles without mem_ready faults.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mem_ready, mem_err       memory handshake (mem_err valid with mem_ready)
//   is_load .. is_halt       decoded class of the current instruction
//   resume                   leave HALT
//   pc_sel, ir_we, rd_we     Mealy control outputs (state + inputs)
//   mem_req, mem_sel, mem_we Moore memory controls
//   halted, fault            Moore status flags
// -----------------------------------------------------------------------------
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic       mem_err,
  input  logic       is_load,
  input  logic       is_store,
  input  logic       is_jump,
  input  logic       branch_taken,
  input  logic       is_halt,
  input  logic       resume,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       rd_we,
  output logic       halted,
  output logic       fault
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int WAIT_W  = (TIMEOUT > 1)   ? $clog2(TIMEOUT)       : 1;
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [WAIT_W-1:0]    wait_q,  wait_d;
  // Cleared by reset and set on the first clock after release, so the first
  // request appears one cycle after rst deasserts and reset drops mem_req
  // combinationally from a register rather than from the rst pin.
  logic                 run_q;

  logic                 waiting;
  logic                 timed_out;
  logic                 replay;

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  assign mem_req = run_q && ((state_q == ST_FETCH) || (state_q == ST_DMEM));
  assign mem_sel = (state_q == ST_DMEM) ? MEM_ALU : MEM_PC;
  assign mem_we  = mem_req && (state_q == ST_DMEM) && is_store;
  assign halted  = (state_q == ST_HALT);
  assign fault   = (state_q == ST_FAULT);

  assign waiting   = mem_req && !mem_ready;
  // mem_ready in the last counted cycle takes precedence over the timeout.
  assign timed_out = waiting && (wait_q == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // Next state, counters and Mealy outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    retry_d = retry_q;
    replay  = 1'b0;
    pc_sel  = PC_OLD;
    ir_we   = 1'b0;
    rd_we   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (mem_req && mem_ready) begin
          if (mem_err) begin
            state_d = ST_FAULT;
          end else begin
            ir_we   = 1'b1;
            pc_sel  = PC_P4;
            state_d = ST_EXEC;
          end
        end else if (timed_out) begin
          state_d = ST_FAULT;
        end
      end

      ST_EXEC: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_jump || branch_taken) begin
          pc_sel  = PC_ALU;
          rd_we   = is_jump;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = ST_DMEM;
        end else begin
          rd_we   = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DMEM: begin
        if (mem_req && mem_ready) begin
          if (!mem_err) begin
            rd_we   = is_load;
            state_d = ST_FETCH;
          end else if (retry_q < RETRY_MAX) begin
            // PC already points past this instruction; step back and refetch.
            pc_sel  = PC_M4;
            retry_d = retry_q + 1'b1;
            replay  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_FAULT;
          end
        end else if (timed_out) begin
          state_d = ST_FAULT;
        end
      end

      ST_HALT: begin
        if (resume) state_d = ST_FETCH;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Retry count survives only the replay path back into FETCH; the
    // FETCH->EXEC->DMEM walk of the replayed instruction keeps it.
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH) && !replay) begin
      retry_d = '0;
    end

    // Wait counter restarts on any state change and saturates at WAIT_LAST.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && (wait_q != WAIT_LAST)) begin
      wait_d = wait_q + 1'b1;
    end else begin
      wait_d = wait_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      retry_q <= '0;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      retry_q <= retry_d;
      wait_q  <= wait_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_seq
//   Directed bench for instr_seq. Inputs are driven 1 time unit after the
//   rising edge and outputs are sampled 3 units later. A small PC register in
//   the bench follows pc_sel so the fetch address sequence can be checked
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_seq;
  import instr_seq_pkg::*;

  // {is_halt, is_jump, branch_taken, is_load, is_store}
  localparam logic [4:0] K_ALU = 5'b00000;
  localparam logic [4:0] K_ST  = 5'b00001;
  localparam logic [4:0] K_LD  = 5'b00010;
  localparam logic [4:0] K_BR  = 5'b00100;
  localparam logic [4:0] K_JMP = 5'b01000;
  localparam logic [4:0] K_HLT = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_ready = 1'b0;
  logic        mem_err = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        is_jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic        is_halt = 1'b0;
  logic        resume = 1'b0;
  logic [1:0]  pc_sel;
  logic        mem_sel, mem_req, mem_we, ir_we, rd_we, halted, fault;

  logic [31:0] pc;
  logic [31:0] alu_tgt = 32'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_seq #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ready    (mem_ready),
    .mem_err      (mem_err),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_jump      (is_jump),
    .branch_taken (branch_taken),
    .is_halt      (is_halt),
    .resume       (resume),
    .pc_sel       (pc_sel),
    .mem_sel      (mem_sel),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_we        (ir_we),
    .rd_we        (rd_we),
    .halted       (halted),
    .fault        (fault)
  );

  // Reference PC driven by the sequencer's select output.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 32'd0;
    end else begin
      case (pc_sel)
        PC_P4:   pc <= pc + 32'd4;
        PC_M4:   pc <= pc - 32'd4;
        PC_ALU:  pc <= alu_tgt;
        default: pc <= pc;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed view {pc_sel, ir_we, rd_we, mem_req, mem_sel, mem_we, halted, fault}.
  task automatic expect_o(input string tag, input logic [1:0] e_pc, input logic e_ir,
                          input logic e_rd, input logic e_req, input logic e_sel,
                          input logic e_we, input logic e_h, input logic e_f);
    check(tag, {23'd0, pc_sel, ir_we, rd_we, mem_req, mem_sel, mem_we, halted, fault},
               {23'd0, e_pc, e_ir, e_rd, e_req, e_sel, e_we, e_h, e_f});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic err, input logic [4:0] k, input logic res);
    mem_ready    = rdy;
    mem_err      = err;
    is_halt      = k[4];
    is_jump      = k[3];
    branch_taken = k[2];
    is_load      = k[1];
    is_store     = k[0];
    resume       = res;
    #3;
  endtask

  // Leaves the bench in the idle cycle right after rst falls.
  task automatic reset_dut();
    rst = 1'b1;
    drive(1'b0, 1'b0, K_ALU, 1'b0);
    step();
    rst = 1'b0;
    #3;
  endtask

  initial begin
    // ---------------- reset ----------------
    step();
    drive(1'b0, 1'b0, K_ALU, 1'b0);
    expect_o("rst_hold", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    drive(1'b1, 1'b0, K_ALU, 1'b0);
    expect_o("rst_ready_ignored", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, K_ALU, 1'b0);
    expect_o("post_rst_idle", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);

    // ---------------- ALU instructions, 2 cycles each ----------------
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, 1'b0, K_ALU, 1'b0);
      expect_o("alu_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
      step();
      drive(1'b1, 1'b0, K_ALU, 1'b0);
      expect_o("alu_exec", PC_OLD, 0, 1, 0, MEM_PC, 0, 0, 0);
      check("alu_pc", pc, 32'(4 * (i + 1)));
    end

    // ---------------- load, ready after 3 wait cycles ----------------
    step();
    drive(1'b1, 1'b0, K_LD, 1'b0);
    expect_o("ld_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    step();
    drive(1'b0, 1'b0, K_LD, 1'b0);
    expect_o("ld_exec", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b0, 1'b0, K_LD, 1'b0);
      expect_o("ld_wait", PC_OLD, 0, 0, 1, MEM_ALU, 0, 0, 0);
    end
    step();
    drive(1'b1, 1'b0, K_LD, 1'b0);
    expect_o("ld_done", PC_OLD, 0, 1, 1, MEM_ALU, 0, 0, 0);

    // ---------------- jump to 100 ----------------
    step();
    alu_tgt = 32'd100;
    drive(1'b1, 1'b0, K_JMP, 1'b0);
    expect_o("jmp_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    check("jmp_fetch_pc", pc, 32'd16);
    step();
    drive(1'b0, 1'b0, K_JMP, 1'b0);
    expect_o("jmp_exec", PC_ALU, 0, 1, 0, MEM_PC, 0, 0, 0);

    // ---------------- halt at 100, resume ----------------
    step();
    drive(1'b1, 1'b0, K_HLT, 1'b0);
    expect_o("hlt_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    check("jmp_pc", pc, 32'd100);
    step();
    drive(1'b0, 1'b0, K_HLT, 1'b0);
    expect_o("hlt_exec", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    step();
    drive(1'b1, 1'b0, K_HLT, 1'b0);
    expect_o("halted", PC_OLD, 0, 0, 0, MEM_PC, 0, 1, 0);
    step();
    drive(1'b0, 1'b0, K_HLT, 1'b1);
    expect_o("halted_resume", PC_OLD, 0, 0, 0, MEM_PC, 0, 1, 0);

    // ---------------- branch taken to 0 (no rd_we) ----------------
    step();
    alu_tgt = 32'd0;
    drive(1'b1, 1'b0, K_BR, 1'b0);
    expect_o("br_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    check("resume_pc", pc, 32'd104);
    step();
    drive(1'b0, 1'b0, K_BR, 1'b0);
    expect_o("br_exec", PC_ALU, 0, 0, 0, MEM_PC, 0, 0, 0);

    // ---------------- store at 0: two errors, then success ----------------
    for (int a = 0; a < 3; a++) begin
      step();
      drive(1'b1, 1'b0, K_ST, 1'b0);
      expect_o("st_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
      check("st_fetch_pc", pc, 32'd0);
      step();
      drive(1'b0, 1'b0, K_ST, 1'b0);
      expect_o("st_exec", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
      step();
      if (a < 2) begin
        drive(1'b1, 1'b1, K_ST, 1'b0);
        expect_o("st_err", PC_M4, 0, 0, 1, MEM_ALU, 1, 0, 0);
      end else begin
        drive(1'b1, 1'b0, K_ST, 1'b0);
        expect_o("st_ok", PC_OLD, 0, 0, 1, MEM_ALU, 1, 0, 0);
      end
    end

    // ---------------- store at 4: four errors -> fault ----------------
    // Three replays are only allowed if the count was cleared after st_ok.
    for (int a = 0; a < 4; a++) begin
      step();
      drive(1'b1, 1'b0, K_ST, 1'b0);
      expect_o("st4_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
      check("st4_fetch_pc", pc, 32'd4);
      step();
      drive(1'b0, 1'b0, K_ST, 1'b0);
      expect_o("st4_exec", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
      step();
      drive(1'b1, 1'b1, K_ST, 1'b0);
      if (a < 3) expect_o("st4_err_replay", PC_M4, 0, 0, 1, MEM_ALU, 1, 0, 0);
      else       expect_o("st4_err_final", PC_OLD, 0, 0, 1, MEM_ALU, 1, 0, 0);
    end
    step();
    drive(1'b0, 1'b0, K_ALU, 1'b0);
    expect_o("retry_fault", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 1);
    check("retry_fault_pc", pc, 32'd8);
    step();
    drive(1'b1, 1'b0, K_ALU, 1'b1);
    expect_o("fault_sticky", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 1);

    // ---------------- fetch timeout ----------------
    reset_dut();
    expect_o("to_idle", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    for (int c = 0; c < 16; c++) begin
      step();
      drive(1'b0, 1'b0, K_ALU, 1'b0);
      expect_o("to_wait", PC_OLD, 0, 0, 1, MEM_PC, 0, 0, 0);
    end
    step();
    drive(1'b1, 1'b0, K_ALU, 1'b0);
    expect_o("to_fault", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 1);
    step();
    drive(1'b0, 1'b0, K_ALU, 1'b0);
    expect_o("to_fault_hold", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 1);

    // ---------------- ready on the last allowed cycle ----------------
    reset_dut();
    for (int c = 0; c < 15; c++) begin
      step();
      drive(1'b0, 1'b0, K_ALU, 1'b0);
      expect_o("late_wait", PC_OLD, 0, 0, 1, MEM_PC, 0, 0, 0);
    end
    step();
    drive(1'b1, 1'b0, K_ALU, 1'b0);
    expect_o("late_ready", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    step();
    drive(1'b0, 1'b0, K_ALU, 1'b0);
    expect_o("late_exec", PC_OLD, 0, 1, 0, MEM_PC, 0, 0, 0);
    check("late_pc", pc, 32'd4);

    // ---------------- reset pulse mid-DMEM ----------------
    step();
    drive(1'b1, 1'b0, K_LD, 1'b0);
    expect_o("rd_fetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    step();
    drive(1'b0, 1'b0, K_LD, 1'b0);
    step();
    drive(1'b0, 1'b0, K_LD, 1'b0);
    expect_o("rd_dmem", PC_OLD, 0, 0, 1, MEM_ALU, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    expect_o("rst_async", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, K_ALU, 1'b0);
    expect_o("rst_release_idle", PC_OLD, 0, 0, 0, MEM_PC, 0, 0, 0);
    step();
    drive(1'b1, 1'b0, K_ALU, 1'b0);
    expect_o("rst_refetch", PC_P4, 1, 0, 1, MEM_PC, 0, 0, 0);
    check("rst_refetch_pc", pc, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
